// File: rtl/sprite_palette_bank_pkg.sv
// Shared types and constants for the sprite palette bank: colour struct,
// power-on palette table and the all-ones flash colour.
package sprite_pkg;

  localparam int unsigned COLOR_W     = 4;
  localparam int unsigned DEF_ENTRIES = 8;

  typedef struct packed {
    logic [COLOR_W-1:0] r;
    logic [COLOR_W-1:0] g;
    logic [COLOR_W-1:0] b;
  } rgb_t;

  localparam rgb_t DEFAULT_PAL [DEF_ENTRIES] = '{
    rgb_t'(12'h070), rgb_t'(12'h0E1), rgb_t'(12'hECA), rgb_t'(12'h05E),
    rgb_t'(12'hE30), rgb_t'(12'h732), rgb_t'(12'h000), rgb_t'(12'h028)
  };

  localparam rgb_t WHITE = rgb_t'('1);

  // Default colour for a palette entry; entries beyond the table are black.
  function automatic rgb_t default_entry(input int unsigned idx);
    rgb_t e;
    e = '0;
    if (idx < DEF_ENTRIES) e = DEFAULT_PAL[idx[2:0]];
    return e;
  endfunction

endpackage

// File: rtl/sprite_palette_bank_palette_ram.sv
// Palette storage: one synchronous read port, one write port, every entry
// reloaded with the default table on reset. Read returns pre-write data.
module palette_ram
  import sprite_pkg::*;
#(
  parameter int unsigned IDX_W = 3,
  parameter int unsigned PAL_W = 2,
  parameter int unsigned RGB_W = 12
) (
  input  logic                   Clk,
  input  logic                   Reset_n,
  input  logic                   rd_en,
  input  logic [PAL_W+IDX_W-1:0] rd_addr,
  output logic [RGB_W-1:0]       rd_data,
  input  logic                   wr_en,
  input  logic [PAL_W+IDX_W-1:0] wr_addr,
  input  logic [RGB_W-1:0]       wr_data
);

  localparam int unsigned ADDR_W  = PAL_W + IDX_W;
  localparam int unsigned DEPTH   = 2 ** ADDR_W;
  localparam int unsigned ENTRIES = 2 ** IDX_W;

  logic [RGB_W-1:0] mem [DEPTH];

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int a = 0; a < DEPTH; a++) begin
        mem[a] <= RGB_W'(default_entry(32'(a) % ENTRIES));
      end
      rd_data <= '0;
    end else begin
      if (wr_en) mem[wr_addr] <= wr_data;
      if (rd_en) rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/sprite_palette_bank.sv
// Two-stage sprite colour lookup with blank-gated palette writes,
// transparency key and frame-timed damage flash.
module sprite_palette_bank
  import sprite_pkg::*;
#(
  parameter int unsigned IDX_W        = 3,
  parameter int unsigned NUM_PAL      = 4,
  parameter int unsigned COLOR_W      = sprite_pkg::COLOR_W,
  parameter int unsigned TRANSP_IDX   = 0,
  parameter int unsigned FLASH_FRAMES = 8,
  localparam int unsigned PAL_W       = $clog2(NUM_PAL)
) (
  input  logic                 Clk,
  input  logic                 Reset_n,
  input  logic                 blank,
  input  logic                 frame_start,
  input  logic                 pix_valid,
  input  logic [IDX_W-1:0]     pix_index,
  input  logic [PAL_W-1:0]     pix_pal,
  input  logic                 wr_valid,
  output logic                 wr_ready,
  input  logic [PAL_W-1:0]     wr_pal,
  input  logic [IDX_W-1:0]     wr_idx,
  input  logic [3*COLOR_W-1:0] wr_rgb,
  input  logic                 flash_req,
  output logic                 out_valid,
  output logic [COLOR_W-1:0]   red,
  output logic [COLOR_W-1:0]   green,
  output logic [COLOR_W-1:0]   blue,
  output logic                 transparent,
  output logic                 flashing
);

  localparam int unsigned RGB_W  = 3 * COLOR_W;
  localparam int unsigned ADDR_W = PAL_W + IDX_W;
  localparam int unsigned CNT_W  = 8;

  logic              s1_valid;
  logic [IDX_W-1:0]  s1_idx;
  logic [RGB_W-1:0]  rd_data;
  logic [ADDR_W-1:0] hold_addr;
  logic [RGB_W-1:0]  hold_data;
  logic [CNT_W-1:0]  flash_cnt;
  logic [CNT_W-1:0]  flash_next_c;
  logic              commit_c;
  logic              accept_c;
  logic              transp_c;
  logic [RGB_W-1:0]  colour_c;

  // wr_ready doubles as the "holding register empty" flag.
  assign accept_c = wr_valid & wr_ready;
  assign commit_c = blank & ~wr_ready;

  palette_ram #(
    .IDX_W (IDX_W),
    .PAL_W (PAL_W),
    .RGB_W (RGB_W)
  ) u_ram (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .rd_en   (pix_valid),
    .rd_addr ({pix_pal, pix_index}),
    .rd_data (rd_data),
    .wr_en   (commit_c),
    .wr_addr (hold_addr),
    .wr_data (hold_data)
  );

  // Holding register: accept one write, release it to the RAM during blanking.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      wr_ready  <= 1'b1;
      hold_addr <= '0;
      hold_data <= '0;
    end else if (accept_c) begin
      wr_ready  <= 1'b0;
      hold_addr <= {wr_pal, wr_idx};
      hold_data <= wr_rgb;
    end else if (commit_c) begin
      wr_ready  <= 1'b1;
    end
  end

  // Flash counter: a request (re)loads and overrides a same-cycle frame tick.
  always_comb begin
    flash_next_c = flash_cnt;
    if (flash_req) begin
      flash_next_c = CNT_W'(FLASH_FRAMES);
    end else if (frame_start && (flash_cnt != '0)) begin
      flash_next_c = flash_cnt - CNT_W'(1);
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      flash_cnt <= '0;
      flashing  <= 1'b0;
    end else begin
      flash_cnt <= flash_next_c;
      flashing  <= (flash_next_c != '0);
    end
  end

  assign transp_c = (s1_idx == IDX_W'(TRANSP_IDX));
  assign colour_c = (flash_cnt[0] && !transp_c) ? '1 : rd_data;

  // Stage 1 tracks the request alongside the RAM read; stage 2 forms the pixel.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      s1_valid    <= 1'b0;
      s1_idx      <= '0;
      out_valid   <= 1'b0;
      transparent <= 1'b0;
      red         <= '0;
      green       <= '0;
      blue        <= '0;
    end else begin
      s1_valid  <= pix_valid;
      s1_idx    <= pix_index;
      out_valid <= s1_valid;
      if (s1_valid) begin
        transparent <= transp_c;
        red         <= colour_c[RGB_W-1 -: COLOR_W];
        green       <= colour_c[2*COLOR_W-1 -: COLOR_W];
        blue        <= colour_c[COLOR_W-1:0];
      end else begin
        transparent <= 1'b0;
        red         <= '0;
        green       <= '0;
        blue        <= '0;
      end
    end
  end

endmodule

// File: tb/tb_sprite_palette_bank.sv
// Directed bench for sprite_palette_bank: lookup latency, transparency,
// blank-gated writes, flash sequencing, read-before-write and reset.
module tb_sprite_palette_bank;

  logic        Clk = 1'b0;
  logic        Reset_n = 1'b0;
  logic        blank = 1'b0;
  logic        frame_start = 1'b0;
  logic        pix_valid = 1'b0;
  logic [2:0]  pix_index = '0;
  logic [1:0]  pix_pal = '0;
  logic        wr_valid = 1'b0;
  logic        wr_ready;
  logic [1:0]  wr_pal = '0;
  logic [2:0]  wr_idx = '0;
  logic [11:0] wr_rgb = '0;
  logic        flash_req = 1'b0;
  logic        out_valid;
  logic [3:0]  red, green, blue;
  logic        transparent;
  logic        flashing;
  logic [11:0] rgb_o;

  int checks = 0;
  int errors = 0;

  logic [11:0] def_tab [8] = '{12'h070, 12'h0E1, 12'hECA, 12'h05E,
                               12'hE30, 12'h732, 12'h000, 12'h028};

  assign rgb_o = {red, green, blue};

  always #5 Clk = ~Clk;

  sprite_palette_bank dut (
    .Clk(Clk), .Reset_n(Reset_n), .blank(blank), .frame_start(frame_start),
    .pix_valid(pix_valid), .pix_index(pix_index), .pix_pal(pix_pal),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_pal(wr_pal), .wr_idx(wr_idx),
    .wr_rgb(wr_rgb), .flash_req(flash_req), .out_valid(out_valid),
    .red(red), .green(green), .blue(blue), .transparent(transparent),
    .flashing(flashing)
  );

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Issue one lookup and return what appears two cycles later.
  task automatic do_lookup(input logic [1:0] pal, input logic [2:0] idx,
                           output logic v, output logic [11:0] rgb, output logic tr);
    pix_valid = 1'b1; pix_pal = pal; pix_index = idx;
    tick();
    pix_valid = 1'b0;
    tick();
    v = out_valid; rgb = rgb_o; tr = transparent;
  endtask

  task automatic pulse_frame();
    frame_start = 1'b1; tick(); frame_start = 1'b0;
  endtask

  task automatic pulse_flash();
    flash_req = 1'b1; tick(); flash_req = 1'b0;
  endtask

  task automatic test_reset();
    Reset_n = 1'b0;
    repeat (3) @(posedge Clk);
    #1;
    checks++;
    if (out_valid !== 1'b0 || rgb_o !== 12'h000 || transparent !== 1'b0 ||
        flashing !== 1'b0 || wr_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_state: ov=%b rgb=%h tr=%b fl=%b rdy=%b, expected 0 000 0 0 1",
               out_valid, rgb_o, transparent, flashing, wr_ready);
    end
    Reset_n = 1'b1;
    tick();
    pix_valid = 1'b1; pix_pal = 2'd2; pix_index = 3'd4;
    tick();
    pix_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL latency_t1: out_valid=%b, expected 0", out_valid);
    end
    tick();
    checks++;
    if (out_valid !== 1'b1 || rgb_o !== 12'hE30 || transparent !== 1'b0) begin
      errors++;
      $display("FAIL latency_t2: ov=%b rgb=%h tr=%b, expected 1 E30 0",
               out_valid, rgb_o, transparent);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0 || rgb_o !== 12'h000) begin
      errors++;
      $display("FAIL idle_zero: ov=%b rgb=%h, expected 0 000", out_valid, rgb_o);
    end
  endtask

  task automatic test_transparent();
    logic v, tr;
    logic [11:0] rgb;
    do_lookup(2'd3, 3'd0, v, rgb, tr);
    checks++;
    if (v !== 1'b1 || rgb !== 12'h070 || tr !== 1'b1) begin
      errors++;
      $display("FAIL transp_plain: ov=%b rgb=%h tr=%b, expected 1 070 1", v, rgb, tr);
    end
    pulse_flash();
    pulse_frame();
    do_lookup(2'd1, 3'd0, v, rgb, tr);
    checks++;
    if (v !== 1'b1 || rgb !== 12'h070 || tr !== 1'b1) begin
      errors++;
      $display("FAIL transp_flash: ov=%b rgb=%h tr=%b, expected 1 070 1", v, rgb, tr);
    end
    do_lookup(2'd0, 3'd2, v, rgb, tr);
    checks++;
    if (v !== 1'b1 || rgb !== 12'hFFF || tr !== 1'b0) begin
      errors++;
      $display("FAIL opaque_flash: ov=%b rgb=%h tr=%b, expected 1 FFF 0", v, rgb, tr);
    end
    repeat (7) pulse_frame();
    checks++;
    if (flashing !== 1'b0) begin
      errors++;
      $display("FAIL flash_clear: flashing=%b, expected 0", flashing);
    end
  endtask

  task automatic test_write_commit();
    logic v, tr;
    logic [11:0] rgb;
    blank = 1'b0;
    wr_valid = 1'b1; wr_pal = 2'd1; wr_idx = 3'd3; wr_rgb = 12'hFFF;
    tick();
    wr_valid = 1'b0;
    checks++;
    if (wr_ready !== 1'b0) begin
      errors++;
      $display("FAIL wr_ready_low: wr_ready=%b, expected 0", wr_ready);
    end
    do_lookup(2'd1, 3'd3, v, rgb, tr);
    checks++;
    if (v !== 1'b1 || rgb !== 12'h05E || wr_ready !== 1'b0) begin
      errors++;
      $display("FAIL pre_commit: ov=%b rgb=%h rdy=%b, expected 1 05E 0", v, rgb, wr_ready);
    end
    blank = 1'b1;
    tick();
    blank = 1'b0;
    checks++;
    if (wr_ready !== 1'b1) begin
      errors++;
      $display("FAIL wr_ready_back: wr_ready=%b, expected 1", wr_ready);
    end
    do_lookup(2'd1, 3'd3, v, rgb, tr);
    checks++;
    if (v !== 1'b1 || rgb !== 12'hFFF) begin
      errors++;
      $display("FAIL post_commit: ov=%b rgb=%h, expected 1 FFF", v, rgb);
    end
    do_lookup(2'd0, 3'd3, v, rgb, tr);
    checks++;
    if (v !== 1'b1 || rgb !== 12'h05E) begin
      errors++;
      $display("FAIL other_pal: ov=%b rgb=%h, expected 1 05E", v, rgb);
    end
  endtask

  task automatic test_flash();
    logic v, tr;
    logic [11:0] rgb;
    logic [11:0] exp;
    pulse_flash();
    for (int k = 8; k >= 1; k--) begin
      exp = (k % 2 == 1) ? 12'hFFF : 12'hECA;
      do_lookup(2'd0, 3'd2, v, rgb, tr);
      checks++;
      if (v !== 1'b1 || rgb !== exp || flashing !== 1'b1) begin
        errors++;
        $display("FAIL flash_count%0d: ov=%b rgb=%h fl=%b, expected 1 %h 1",
                 k, v, rgb, flashing, exp);
      end
      pulse_frame();
    end
    do_lookup(2'd0, 3'd2, v, rgb, tr);
    checks++;
    if (v !== 1'b1 || rgb !== 12'hECA || flashing !== 1'b0) begin
      errors++;
      $display("FAIL flash_done: ov=%b rgb=%h fl=%b, expected 1 ECA 0", v, rgb, flashing);
    end
    pulse_frame();
    checks++;
    if (flashing !== 1'b0) begin
      errors++;
      $display("FAIL flash_floor: flashing=%b, expected 0", flashing);
    end
    pulse_flash();
    pulse_frame();
    flash_req = 1'b1; frame_start = 1'b1;
    tick();
    flash_req = 1'b0; frame_start = 1'b0;
    do_lookup(2'd0, 3'd2, v, rgb, tr);
    checks++;
    if (v !== 1'b1 || rgb !== 12'hECA || flashing !== 1'b1) begin
      errors++;
      $display("FAIL load_wins: ov=%b rgb=%h fl=%b, expected 1 ECA 1", v, rgb, flashing);
    end
    pulse_frame();
    do_lookup(2'd0, 3'd2, v, rgb, tr);
    checks++;
    if (v !== 1'b1 || rgb !== 12'hFFF) begin
      errors++;
      $display("FAIL after_reload: ov=%b rgb=%h, expected 1 FFF", v, rgb);
    end
    repeat (7) pulse_frame();
  endtask

  task automatic test_read_during_commit();
    blank = 1'b0;
    wr_valid = 1'b1; wr_pal = 2'd2; wr_idx = 3'd5; wr_rgb = 12'h123;
    tick();
    wr_valid = 1'b0;
    blank = 1'b1;
    pix_valid = 1'b1; pix_pal = 2'd2; pix_index = 3'd5;
    tick();
    blank = 1'b0;
    tick();
    pix_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || rgb_o !== 12'h732) begin
      errors++;
      $display("FAIL rbw_old: ov=%b rgb=%h, expected 1 732", out_valid, rgb_o);
    end
    tick();
    checks++;
    if (out_valid !== 1'b1 || rgb_o !== 12'h123 || wr_ready !== 1'b1) begin
      errors++;
      $display("FAIL rbw_new: ov=%b rgb=%h rdy=%b, expected 1 123 1",
               out_valid, rgb_o, wr_ready);
    end
    tick();
  endtask

  task automatic test_reset_midstream();
    logic v, tr;
    logic [11:0] rgb;
    blank = 1'b0;
    wr_valid = 1'b1; wr_pal = 2'd0; wr_idx = 3'd1; wr_rgb = 12'hABC;
    tick();
    wr_valid = 1'b0;
    pix_valid = 1'b1; pix_pal = 2'd0; pix_index = 3'd4;
    tick();
    pix_valid = 1'b0;
    Reset_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || wr_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_async: ov=%b rdy=%b, expected 0 1", out_valid, wr_ready);
    end
    tick();
    tick();
    Reset_n = 1'b1;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_drop: out_valid=%b, expected 0", out_valid);
    end
    blank = 1'b1;
    tick();
    tick();
    blank = 1'b0;
    for (int p = 0; p < 4; p++) begin
      for (int i = 0; i < 8; i++) begin
        do_lookup(2'(p), 3'(i), v, rgb, tr);
        checks++;
        if (v !== 1'b1 || rgb !== def_tab[i] || tr !== (i == 0)) begin
          errors++;
          $display("FAIL default_p%0d_i%0d: ov=%b rgb=%h tr=%b, expected 1 %h %b",
                   p, i, v, rgb, tr, def_tab[i], (i == 0));
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_transparent();
    test_write_commit();
    test_flash();
    test_read_during_commit();
    test_reset_midstream();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
